// File: rtl/divclk_meter.sv
// divclk_meter: measures period and high time of a clk-synchronous divided clock and
// hands each result over a valid/ready slot. Define DIVCLK_METER_DUTY_EN to build in high-time measurement.

module divclk_meter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             enable,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             sat,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [WIDTH-1:0] edge_count,
    output logic             overrun,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEAS
    } state_e;

    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

    state_e           state_q, state_d;
    logic             prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             sat_q, sat_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic rise;
    logic counting;
    logic tmo_hit;
    logic complete;
    logic load;

    assign rise     = div_clk & ~prev_q;
    assign counting = enable && (state_q != ST_IDLE);
    // A rise wins over a timeout that falls on the same cycle, so a full-scale period still completes.
    assign tmo_hit  = counting && !rise && (cnt_q >= TIMEOUT_C);
    assign complete = enable && (state_q == ST_MEAS) && rise;
    assign load     = complete && (!valid_q || meas_ready);

    // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (rise) state_d = ST_MEAS;
                         else if (tmo_hit) state_d = ST_ARM;
                ST_MEAS: if (rise) state_d = ST_MEAS;
                         else if (tmo_hit) state_d = ST_ARM;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!counting || tmo_hit) begin
            cnt_d = '0;
        end else if (rise) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        period_d  = period_q;
        sat_d     = sat_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q | tmo_hit;
        edge_d    = edge_q;

        if (state_q == ST_IDLE) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            edge_d    = '0;
        end else if (counting && rise) begin
            edge_d = edge_q + CNT_ONE;
        end

        if (complete) begin
            if (load) begin
                valid_d  = 1'b1;
                period_d = cnt_q;
                sat_d    = (cnt_q == CNT_MAX);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && meas_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            edge_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= div_clk;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef DIVCLK_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] high_q, high_d;

    always_comb begin
        hcnt_d = hcnt_q;
        if (!counting || tmo_hit) begin
            hcnt_d = '0;
        end else if (rise) begin
            hcnt_d = CNT_ONE;
        end else if (div_clk && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end
    end

    always_comb begin
        high_d = high_q;
        if (load) begin
            high_d = hcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    assign high_time = '0;
`endif

    assign period     = period_q;
    assign sat        = sat_q;
    assign meas_valid = valid_q;
    assign edge_count = edge_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule
